// File: rtl/axis_result_tx.sv
// axis_result_tx: packs narrow result elements little-endian into AXI-Stream beats via a small beat FIFO
module axis_result_tx #(
    parameter int DATA_WIDTH  = 128,
    parameter int ELEM_WIDTH  = 16,
    parameter int FRAME_ELEMS = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  elem_valid,
    input  logic [ELEM_WIDTH-1:0] elem_data,
    output logic                  elem_ready,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic                  frame_done
);
    localparam int LANES = DATA_WIDTH / ELEM_WIDTH;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int EW = FRAME_ELEMS > 1 ? $clog2(FRAME_ELEMS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [EW-1:0] LAST_ELEM = EW'(FRAME_ELEMS - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [LW-1:0] lane_cnt;
    logic [EW-1:0] elem_cnt;
    logic [DATA_WIDTH-1:0] asm_reg, beat;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic accept, eof, close, pop;

    assign elem_ready    = count != FULL;
    assign M_AXIS_TVALID = count != '0;
    assign M_AXIS_TDATA  = fifo_data[rd_ptr];
    assign M_AXIS_TLAST  = fifo_last[rd_ptr];

    always_comb begin
        accept = elem_valid && elem_ready;
        eof    = elem_cnt == LAST_ELEM;
        close  = accept && (eof || lane_cnt == LAST_LANE);
        pop    = M_AXIS_TVALID && M_AXIS_TREADY;
        beat   = asm_reg | (DATA_WIDTH'(elem_data) << (lane_cnt * ELEM_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt   <= '0;
            elem_cnt   <= '0;
            asm_reg    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_last  <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
        end else begin
            if (accept) begin
                asm_reg  <= close ? '0 : beat;
                lane_cnt <= close ? '0 : lane_cnt + 1'b1;
                elem_cnt <= eof ? '0 : elem_cnt + 1'b1;
            end
            if (close) begin
                fifo_data[wr_ptr] <= beat;
                fifo_last[wr_ptr] <= eof;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + (AW + 1)'(close) - (AW + 1)'(pop);
            frame_done <= pop && M_AXIS_TLAST;
        end
    end
endmodule

// File: tb/tb_axis_result_tx.sv
// tb_axis_result_tx: three packer instances (10, 16 and 1 elements per frame) checked against a frame/lane arithmetic model
module tb_axis_result_tx;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] v, tr, rdy, tv, tl, fd;
    logic [15:0] d [3];
    logic [127:0] td [3];
    int ntests = 0, nfail = 0;

    logic [15:0] acc [3][1024];
    logic [127:0] capd [3][512];
    logic capl [3][512];
    int nacc [3], ncap [3], nfd [3];
    bit rdone;

    typedef struct {
        int inst;
        int first;
        int nel;
        logic [127:0] b0;
        logic l0;
        logic [127:0] b1;
        logic l1;
        int nfd;
    } row_t;
    row_t tbl [3];

    always #5 clk = ~clk;

    axis_result_tx u0 (.clk(clk), .rst(rst), .elem_valid(v[0]), .elem_data(d[0]), .elem_ready(rdy[0]),
        .M_AXIS_TDATA(td[0]), .M_AXIS_TVALID(tv[0]), .M_AXIS_TREADY(tr[0]), .M_AXIS_TLAST(tl[0]), .frame_done(fd[0]));
    axis_result_tx #(.FRAME_ELEMS(16)) u1 (.clk(clk), .rst(rst), .elem_valid(v[1]), .elem_data(d[1]), .elem_ready(rdy[1]),
        .M_AXIS_TDATA(td[1]), .M_AXIS_TVALID(tv[1]), .M_AXIS_TREADY(tr[1]), .M_AXIS_TLAST(tl[1]), .frame_done(fd[1]));
    axis_result_tx #(.FRAME_ELEMS(1)) u2 (.clk(clk), .rst(rst), .elem_valid(v[2]), .elem_data(d[2]), .elem_ready(rdy[2]),
        .M_AXIS_TDATA(td[2]), .M_AXIS_TVALID(tv[2]), .M_AXIS_TREADY(tr[2]), .M_AXIS_TLAST(tl[2]), .frame_done(fd[2]));

    // Handshakes seen at the falling edge are the ones that complete on the next rising edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (v[i] && rdy[i]) begin
                acc[i][nacc[i]] = d[i];
                nacc[i]++;
            end
            if (tv[i] && tr[i]) begin
                capd[i][ncap[i]] = td[i];
                capl[i][ncap[i]] = tl[i];
                ncap[i]++;
            end
            if (fd[i]) nfd[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(string nm, logic [128:0] act, logic [128:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_elem(int i, logic [15:0] val);
        v[i] = 1'b1;
        d[i] = val;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (rdy[i]) begin
                @(posedge clk);
                #1;
                v[i] = 1'b0;
                return;
            end
        end
        chk($sformatf("push timeout inst%0d", i), 1, 0);
        v[i] = 1'b0;
    endtask

    task automatic drain(int i);
        for (int t = 0; t < 2000 && tv[i]; t++) @(negedge clk);
        chk($sformatf("drain inst%0d", i), tv[i], 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Element k of the stream sits at frame k/fe, frame position f = k%fe, beat f/8, lane f%8
    task automatic verify(int i, int fe, int a0, int c0, int f0, int nfr, string nm);
        logic [127:0] ed [64];
        logic el [64];
        int bpf, nb, f, b;
        bpf = (fe + 7) / 8;
        nb = nfr * bpf;
        for (int k = 0; k < nb; k++) begin
            ed[k] = '0;
            el[k] = 1'b0;
        end
        for (int k = 0; k < nfr * fe; k++) begin
            f = k % fe;
            b = (k / fe) * bpf + f / 8;
            ed[b] = ed[b] | (128'(acc[i][a0 + k]) << (16 * (f % 8)));
            el[b] = (f / 8) == bpf - 1;
        end
        chk({nm, " elems"}, nacc[i] - a0, nfr * fe);
        chk({nm, " beats"}, ncap[i] - c0, nb);
        for (int k = 0; k < nb; k++)
            chk($sformatf("%s beat%0d {last,data}", nm, k), {capl[i][c0 + k], capd[i][c0 + k]}, {el[k], ed[k]});
        chk({nm, " frame_done"}, nfd[i] - f0, nfr);
    endtask

    initial begin
        int a0, c0, f0, i;
        logic [127:0] hold;
        tbl[0] = '{0, 1, 10, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0, 128'h000a_0009, 1'b1, 1};
        tbl[1] = '{1, 1, 16, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0,
                   128'h0010_000f_000e_000d_000c_000b_000a_0009, 1'b1, 1};
        tbl[2] = '{2, 5, 2, 128'h5, 1'b1, 128'h6, 1'b1, 2};
        rst = 1'b1;
        v = '0;
        tr = '0;
        for (int k = 0; k < 3; k++) d[k] = '0;
        #12;
        chk("reset tvalid", tv, 0);
        chk("reset tlast", tl, 0);
        chk("reset frame_done", fd, 0);
        chk("reset tdata", td[0], 0);
        chk("reset elem_ready", rdy, 3'b111);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            i = tbl[r].inst;
            tr[i] = 1'b1;
            c0 = ncap[i];
            f0 = nfd[i];
            for (int k = 0; k < tbl[r].nel; k++) push_elem(i, 16'(tbl[r].first + k));
            drain(i);
            chk($sformatf("row%0d beats", r), ncap[i] - c0, 2);
            chk($sformatf("row%0d beat0", r), {capl[i][c0], capd[i][c0]}, {tbl[r].l0, tbl[r].b0});
            chk($sformatf("row%0d beat1", r), {capl[i][c0 + 1], capd[i][c0 + 1]}, {tbl[r].l1, tbl[r].b1});
            chk($sformatf("row%0d frame_done", r), nfd[i] - f0, tbl[r].nfd);
        end

        do_reset();
        tr[0] = 1'b0;
        a0 = nacc[0];
        c0 = ncap[0];
        f0 = nfd[0];
        for (int k = 0; k < 20; k++) begin
            push_elem(0, 16'(16'h100 + k));
            if (k == 6) chk("bp no beat before lane 7", tv[0], 0);
            if (k == 7) chk("bp beat latency", tv[0], 1);
        end
        chk("bp full elem_ready", rdy[0], 0);
        chk("bp nothing popped", ncap[0] - c0, 0);
        hold = td[0];
        repeat (5) @(posedge clk);
        #1;
        chk("bp stall tdata", td[0], hold);
        chk("bp stall tvalid", tv[0], 1);
        chk("bp stall tlast", tl[0], 0);
        chk("bp stall elem_ready", rdy[0], 0);
        tr[0] = 1'b1;
        drain(0);
        verify(0, 10, a0, c0, f0, 2, "bp");

        do_reset();
        tr[0] = 1'b0;
        for (int k = 0; k < 11; k++) push_elem(0, 16'hbad0 + 16'(k));
        chk("pre-reset beat buffered", tv[0], 1);
        rst = 1'b1;
        #1;
        chk("reset async tvalid", tv[0], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held tvalid", tv[0], 0);
        chk("reset held elem_ready", rdy[0], 1);
        rst = 1'b0;
        tr[0] = 1'b1;
        a0 = nacc[0];
        c0 = ncap[0];
        f0 = nfd[0];
        for (int k = 0; k < 10; k++) push_elem(0, 16'(k + 1));
        drain(0);
        verify(0, 10, a0, c0, f0, 1, "post-reset");
        chk("post-reset beat0 const", {capl[0][c0], capd[0][c0]}, {tbl[0].l0, tbl[0].b0});
        chk("post-reset beat1 const", {capl[0][c0 + 1], capd[0][c0 + 1]}, {tbl[0].l1, tbl[0].b1});

        a0 = nacc[0];
        c0 = ncap[0];
        f0 = nfd[0];
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    push_elem(0, 16'($urandom));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    tr[0] = 1'($urandom_range(0, 1));
                end
                tr[0] = 1'b1;
            end
        join
        drain(0);
        verify(0, 10, a0, c0, f0, 20, "random");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
